// File: rtl/fnn_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FNN core.
// Build option: define FNN_LEAKY_RELU_EN to switch the activation from ReLU to leaky ReLU (y>>>3).
package fnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2,
        DONE = 2'd3
    } fnn_state_t;

    // Wide enough that N full-scale products plus a shifted bias cannot overflow before saturation.
    function automatic int acc_width(input int dw, input int n, input int frac);
        return 2 * dw + $clog2(n) + frac + 1;
    endfunction

    function automatic int ram_depth(input int layers, input int n);
        return layers * n * n + layers * n;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] y);
        return (y < 0) ? 64'sd0 : y;
    endfunction

    function automatic logic signed [63:0] leaky(input logic signed [63:0] y);
        return (y < 0) ? (y >>> 3) : y;
    endfunction

    function automatic logic signed [63:0] act_fn(input logic signed [63:0] y);
`ifdef FNN_LEAKY_RELU_EN
        return leaky(y);
`else
        return relu(y);
`endif
    endfunction

endpackage

// File: rtl/fnn_mac_unit.sv
// Shared MAC datapath: bias preload, signed multiply-accumulate, shift, saturate, activate.
// Activation follows the FNN_LEAKY_RELU_EN build option through fnn_pkg::act_fn.
module fnn_mac_unit
    import fnn_pkg::*;
#(
    parameter int DW    = 8,
    parameter int N     = 4,
    parameter int FRAC  = 0,
    parameter int ACC_W = acc_width(DW, N, FRAC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic signed [DW-1:0] bias,
    input  logic                 mac_en,
    input  logic signed [DW-1:0] w,
    input  logic signed [DW-1:0] a,
    output logic signed [DW-1:0] fy
);

    logic signed [ACC_W-1:0]  acc;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACC_W-1:0]  acc_shr;

    assign prod    = w * a;
    assign acc_shr = acc >>> FRAC;

    // Result is always inside the DW range after sat, so the truncation is lossless.
    assign fy = DW'(act_fn(sat(64'(acc_shr), DW)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (load) begin
            acc <= ACC_W'(bias) <<< FRAC;
        end else if (mac_en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fnn_seq_core.sv
// Time-multiplexed fully-connected network: one MAC walks every neuron of every layer.
// Activation is ReLU, or leaky ReLU when FNN_LEAKY_RELU_EN is defined (see fnn_pkg).
//
// state | meaning
// IDLE  | ready for a vector; config writes allowed
// MAC   | accumulate W[l][n][k]*A[k], one k per cycle
// ACT   | saturate/activate neuron n, preload next bias
// DONE  | result held on out_data until out_ready
module fnn_seq_core
    import fnn_pkg::*;
#(
    parameter int N      = 4,
    parameter int LAYERS = 4,
    parameter int DW     = 8,
    parameter int FRAC   = 0,
    parameter int AW     = $clog2(LAYERS * N * N + LAYERS * N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_data,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_wdata,
    output logic            cfg_err
);

    localparam int RAM_D = ram_depth(LAYERS, N);
    localparam int W_SZ  = LAYERS * N * N;
    localparam int ACC_W = acc_width(DW, N, FRAC);
    localparam int KW    = idx_width(N);
    localparam int LW    = idx_width(LAYERS);

    logic [DW-1:0] ram [0:RAM_D-1];

    fnn_state_t state;
    fnn_state_t state_nxt;

    logic [LW-1:0] l_cnt;
    logic [KW-1:0] n_cnt;
    logic [KW-1:0] k_cnt;

    logic signed [DW-1:0] act_a [N];
    logic signed [DW-1:0] act_b [N];

    logic                 accept;
    logic                 cfg_ok;
    logic                 last_k;
    logic                 last_n;
    logic                 last_l;
    logic                 mac_en;
    logic                 load;
    logic [AW-1:0]        w_addr;
    logic [AW-1:0]        b0_addr;
    logic [AW-1:0]        b_addr_nxt;
    logic signed [DW-1:0] bias_val;
    logic signed [DW-1:0] w_val;
    logic signed [DW-1:0] fy;

    assign last_k = (k_cnt == KW'(N - 1));
    assign last_n = (n_cnt == KW'(N - 1));
    assign last_l = (l_cnt == LW'(LAYERS - 1));

    assign accept = in_valid && in_ready;
    assign cfg_ok = cfg_we && (state == IDLE) && (int'(cfg_addr) < RAM_D);

    assign w_addr  = AW'(int'(l_cnt) * N * N + int'(n_cnt) * N + int'(k_cnt));
    assign b0_addr = AW'(W_SZ);

    always_comb begin
        b_addr_nxt = b0_addr;
        if (!last_n) begin
            b_addr_nxt = AW'(W_SZ + int'(l_cnt) * N + int'(n_cnt) + 1);
        end else if (!last_l) begin
            b_addr_nxt = AW'(W_SZ + (int'(l_cnt) + 1) * N);
        end
    end

    // A write to B[0][0] in the accept cycle must be seen by the vector being accepted.
    always_comb begin
        bias_val = ram[b_addr_nxt];
        if (state == IDLE) begin
            bias_val = (cfg_ok && (cfg_addr == b0_addr)) ? cfg_wdata : ram[b0_addr];
        end
    end

    assign w_val = ram[w_addr];

    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            ram[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = MAC;
            MAC:  if (last_k) state_nxt = ACT;
            ACT:  state_nxt = (last_n && last_l) ? DONE : MAC;
            DONE: if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        mac_en   = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            MAC:  mac_en = 1'b1;
            ACT:  load   = 1'b1;
            default: ;
        endcase
    end

    fnn_mac_unit #(
        .DW    (DW),
        .N     (N),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .bias   (bias_val),
        .mac_en (mac_en),
        .w      (w_val),
        .a      (act_a[k_cnt]),
        .fy     (fy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_cnt     <= '0;
            n_cnt     <= '0;
            k_cnt     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < N; i++) begin
                act_a[i] <= '0;
                act_b[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        l_cnt <= '0;
                        n_cnt <= '0;
                        k_cnt <= '0;
                        for (int i = 0; i < N; i++) begin
                            act_a[i] <= in_data[DW*i +: DW];
                        end
                    end
                end
                MAC: begin
                    k_cnt <= last_k ? '0 : k_cnt + 1'b1;
                end
                ACT: begin
                    if (last_n) begin
                        // Layer complete: the finished buffer becomes the next layer's input.
                        for (int i = 0; i < N; i++) begin
                            act_a[i] <= (KW'(i) == n_cnt) ? fy : act_b[i];
                        end
                        n_cnt <= '0;
                        l_cnt <= last_l ? '0 : l_cnt + 1'b1;
                    end else begin
                        act_b[n_cnt] <= fy;
                        n_cnt        <= n_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        for (int i = 0; i < N; i++) begin
                            out_data[DW*i +: DW] <= act_a[i];
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fnn_seq_core.sv
// Self-checking bench for fnn_seq_core: vector table plus hand-written handshake/config/reset sequences.
module tb_fnn_seq_core;

    localparam int N      = 4;
    localparam int LAYERS = 4;
    localparam int DW     = 8;
    localparam int FRAC   = 0;
    localparam int AW     = $clog2(LAYERS * N * N + LAYERS * N);
    localparam int RAM_D  = LAYERS * N * N + LAYERS * N;
    localparam int W_SZ   = LAYERS * N * N;
    localparam int VW     = N * DW;
    localparam int LAT    = LAYERS * N * (N + 1) + 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          cfg_err;

    fnn_seq_core #(
        .N      (N),
        .LAYERS (LAYERS),
        .DW     (DW),
        .FRAC   (FRAC),
        .AW     (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_now = 0;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int            sh [0:RAM_D-1];
    logic [VW-1:0] sb_q [$];

    typedef struct {
        int            pat;
        logic [VW-1:0] in_v;
        logic [VW-1:0] exp_v;
        bit            use_model;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int msat(input int x);
        int hi;
        int lo;
        hi = (1 <<< (DW - 1)) - 1;
        lo = -(1 <<< (DW - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic int mact(input int y);
`ifdef FNN_LEAKY_RELU_EN
        return (y >= 0) ? y : (y >>> 3);
`else
        return (y >= 0) ? y : 0;
`endif
    endfunction

    function automatic logic [VW-1:0] model(input logic [VW-1:0] v);
        int a [N];
        int b [N];
        int acc;
        logic signed [DW-1:0] e;
        logic [VW-1:0] r;
        for (int k = 0; k < N; k++) begin
            e = v[DW*k +: DW];
            a[k] = e;
        end
        for (int l = 0; l < LAYERS; l++) begin
            for (int n = 0; n < N; n++) begin
                acc = sh[W_SZ + l * N + n] <<< FRAC;
                for (int k = 0; k < N; k++) begin
                    acc += sh[l * N * N + n * N + k] * a[k];
                end
                b[n] = mact(msat(acc >>> FRAC));
            end
            a = b;
        end
        r = '0;
        for (int n = 0; n < N; n++) begin
            r[DW*n +: DW] = DW'(a[n]);
        end
        return r;
    endfunction

    task automatic cfg_write(input int addr, input int data);
        logic signed [DW-1:0] t;
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_wdata = DW'(data);
        @(negedge clk);
        cfg_we = 1'b0;
        t = DW'(data);
        if (addr < RAM_D) sh[addr] = t;
    endtask

    task automatic load_pattern(input int p);
        int w;
        for (int l = 0; l < LAYERS; l++) begin
            for (int n = 0; n < N; n++) begin
                for (int k = 0; k < N; k++) begin
                    case (p)
                        0: w = (n == k) ? 1 : 0;
                        1: w = 127;
                        2: w = (n == k) ? ((l == 0) ? -1 : 1) : 0;
                        default: w = int'($urandom_range(0, 60)) - 30;
                    endcase
                    cfg_write(l * N * N + n * N + k, w);
                end
            end
        end
        for (int i = 0; i < LAYERS * N; i++) begin
            cfg_write(W_SZ + i, (p == 3) ? int'($urandom_range(0, 80)) - 40 : 0);
        end
    endtask

    task automatic send_vec(input logic [VW-1:0] v, input logic [VW-1:0] exp, output int acc_cyc);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_data  = v;
        in_valid = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc_now;
    endtask

    task automatic wait_out(input string name, input int acc_cyc);
        int guard;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({name, "_latency"}, 64'(cyc_now - acc_cyc), 64'(LAT));
    endtask

    task automatic take_out(input string name);
        logic [VW-1:0] exp;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 1'b1, 1'b0);
            exp = 'x;
        end else begin
            exp = sb_q.pop_front();
        end
        check({name, "_data"}, out_data, exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_valid_drop"}, out_valid, 1'b0);
        check({name, "_ready_back"}, in_ready, 1'b1);
    endtask

    int            acc_cyc;
    logic [VW-1:0] exp_v;
    logic [VW-1:0] held;
    logic [VW-1:0] v;
    int            cur_pat;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        for (int i = 0; i < RAM_D; i++) sh[i] = 0;

        tbl[0] = '{0, 32'h04030201, 32'h04030201, 1'b0};
`ifdef FNN_LEAKY_RELU_EN
        tbl[1] = '{0, 32'h7F000AFB, 32'h7F000AFF, 1'b0};
        tbl[4] = '{1, 32'h80808080, 32'hF0F0F0F0, 1'b0};
        tbl[5] = '{2, 32'h10101010, 32'hFFFFFFFF, 1'b0};
`else
        tbl[1] = '{0, 32'h7F000AFB, 32'h7F000A00, 1'b0};
        tbl[4] = '{1, 32'h80808080, 32'h00000000, 1'b0};
        tbl[5] = '{2, 32'h10101010, 32'h00000000, 1'b0};
`endif
        tbl[2] = '{1, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b0};
        tbl[3] = '{1, 32'h01010101, 32'h7F7F7F7F, 1'b0};
        for (int i = 6; i < 9; i++) tbl[i] = '{3, VW'($urandom()), '0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_cfg_err", cfg_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        cur_pat = -1;
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].pat != cur_pat) begin
                load_pattern(tbl[i].pat);
                cur_pat = tbl[i].pat;
            end
            exp_v = tbl[i].use_model ? model(tbl[i].in_v) : tbl[i].exp_v;
            send_vec(tbl[i].in_v, exp_v, acc_cyc);
            wait_out($sformatf("vec%0d", i), acc_cyc);
            take_out($sformatf("vec%0d", i));
        end
        check("cfg_err_valid_write", cfg_err, 1'b0);

        // Back-pressure: result held, input ignored, ready returns one cycle after handshake.
        v = VW'($urandom());
        send_vec(v, model(v), acc_cyc);
        wait_out("hold", acc_cyc);
        held = out_data;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = ~v;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_data_stable", out_data, held);
            check("hold_in_ready_low", in_ready, 1'b0);
            check("hold_valid_high", out_valid, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        take_out("hold");
        @(posedge clk);
        #1;
        check("hold_no_stray_accept", in_ready, 1'b1);

        // Config write during MAC is rejected and leaves the RAM alone.
        v = VW'($urandom());
        send_vec(v, model(v), acc_cyc);
        @(negedge clk);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = '0;
        cfg_wdata = 8'h55;
        @(posedge clk);
        #1;
        check("cfg_err_busy_pulse", cfg_err, 1'b1);
        @(negedge clk);
        cfg_we = 1'b0;
        @(posedge clk);
        #1;
        check("cfg_err_busy_clear", cfg_err, 1'b0);
        wait_out("busy_write", acc_cyc);
        take_out("busy_write");

        // Out-of-range address in IDLE is rejected.
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(RAM_D);
        cfg_wdata = 8'h7F;
        @(posedge clk);
        #1;
        check("cfg_err_range_pulse", cfg_err, 1'b1);
        @(negedge clk);
        cfg_we = 1'b0;
        @(posedge clk);
        #1;
        check("cfg_err_range_clear", cfg_err, 1'b0);
        v = VW'($urandom());
        send_vec(v, model(v), acc_cyc);
        wait_out("after_range", acc_cyc);
        take_out("after_range");

        // Bias write in the accept cycle is used by that same vector.
        load_pattern(0);
        @(negedge clk);
        sh[W_SZ]  = 5;
        v         = 32'h04030201;
        cfg_we    = 1'b1;
        cfg_addr  = AW'(W_SZ);
        cfg_wdata = 8'd5;
        in_valid  = 1'b1;
        in_data   = v;
        sb_q.push_back(model(v));
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        acc_cyc  = cyc_now;
        check("same_cycle_cfg_err", cfg_err, 1'b0);
        check("same_cycle_expect", sb_q[0], 32'h04030206);
        wait_out("same_cycle", acc_cyc);
        take_out("same_cycle");

        // Reset mid-run aborts the vector; the RAM keeps its contents.
        v = 32'h0A0B0C0D;
        send_vec(v, model(v), acc_cyc);
        repeat (40) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready_after", in_ready, 1'b1);
        check("midrst_valid_after", out_valid, 1'b0);
        v = 32'h11223344;
        send_vec(v, model(v), acc_cyc);
        wait_out("post_reset", acc_cyc);
        take_out("post_reset");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
